// File: rtl/comar_pkg.sv
// Shared constants, state encoding and single-step LFSR helper for COMAR mask generators.
package comar_pkg;

  localparam int unsigned LFSR_W        = 32;
  localparam int unsigned TAP_A         = 31;
  localparam int unsigned TAP_B         = 21;
  localparam int unsigned TAP_C         = 1;
  localparam int unsigned TAP_D         = 0;
  localparam int unsigned MASKS_PER_AND = 6;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2
  } state_t;

  // One Fibonacci shift: feedback enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step1(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/comar_lfsr_step.sv
// Pure combinational N-step unrolled LFSR next-state.
//   s        : current LFSR state
//   s_next_c : state after N shifts
module comar_lfsr_step
  import comar_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic [LFSR_W-1:0] s,
  output logic [LFSR_W-1:0] s_next_c
);

  always_comb begin
    logic [LFSR_W-1:0] acc;
    acc = s;
    for (int i = 0; i < int'(N); i++) begin
      acc = lfsr_step1(acc);
    end
    s_next_c = acc;
  end

endmodule

// File: rtl/comar_mask_gen.sv
// Fresh-randomness source for one COMAR 2-share AND gadget.
//   clk, rst_n : clock, async active-low reset
//   seed, seed_valid, seed_ready : seed handshake
//   en         : gadget consumes r and the LFSR advances one 6-step block
//   r          : six masks, taken straight from LFSR flops
//   common_out : registered parity of r[5:2] from the previous enabled cycle
//   mask_valid : r/common_out carry usable randomness
module comar_mask_gen
  import comar_pkg::*;
#(
  parameter int unsigned        WARMUP_CYCLES = 16,
  parameter logic [LFSR_W-1:0]  ZERO_SEED_SUB = 32'h0000_0001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LFSR_W-1:0]        seed,
  input  logic                     seed_valid,
  output logic                     seed_ready,
  input  logic                     en,
  output logic [MASKS_PER_AND-1:0] r,
  output logic                     common_out,
  output logic                     mask_valid
);

  localparam int unsigned CNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

  state_t            state, state_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n, lfsr_adv, seed_eff;
  logic [CNT_W-1:0]  warm_cnt, warm_n;
  logic              common_n;
  logic              accept;

  comar_lfsr_step #(.N(MASKS_PER_AND)) u_step (
    .s        (lfsr),
    .s_next_c (lfsr_adv)
  );

  // State and datapath registers; mask_valid/seed_ready are flops decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNSEEDED;
      lfsr       <= '0;
      warm_cnt   <= '0;
      common_out <= 1'b0;
      mask_valid <= 1'b0;
      seed_ready <= 1'b1;
    end else begin
      state      <= state_n;
      lfsr       <= lfsr_n;
      warm_cnt   <= warm_n;
      common_out <= common_n;
      mask_valid <= (state_n == RUN);
      seed_ready <= (state_n != WARMUP);
    end
  end

  // Each r bit is an independent AND of one LFSR flop with the registered valid bit.
  assign r = lfsr[MASKS_PER_AND-1:0] & {MASKS_PER_AND{mask_valid}};

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr;
    warm_n   = warm_cnt;
    common_n = common_out;
    accept   = seed_valid & seed_ready;
    seed_eff = (seed == '0) ? ZERO_SEED_SUB : seed;

    case (state)
      UNSEEDED, RUN: begin
        if (accept) begin
          // Reseed wins over en: the presented r is not consumed.
          lfsr_n   = seed_eff;
          warm_n   = CNT_W'(WARMUP_CYCLES);
          common_n = 1'b0;
          state_n  = (WARMUP_CYCLES > 0) ? WARMUP : RUN;
        end else if (state == RUN && en) begin
          lfsr_n   = lfsr_adv;
          common_n = ^lfsr[MASKS_PER_AND-1:2];
        end
      end
      WARMUP: begin
        lfsr_n = lfsr_adv;
        warm_n = warm_cnt - CNT_W'(1);
        if (warm_cnt == CNT_W'(1)) begin
          state_n = RUN;
        end
      end
      default: state_n = UNSEEDED;
    endcase
  end

endmodule

// File: tb/tb_comar_mask_gen.sv
module tb_comar_mask_gen;

  typedef struct {
    logic [5:0] r;
    logic       c;
    logic       v;
    logic       rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] seed0, seed1;
  logic        sv0, sv1, en0, en1;
  logic        rdy0, rdy1, co0, co1, mv0, mv1;
  logic [5:0]  r0, r1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int          m_st[2];
  logic [31:0] m_lf[2];
  int          m_cnt[2];
  logic        m_co[2];
  int          m_w[2] = '{0, 16};

  always #5 clk = ~clk;

  comar_mask_gen #(.WARMUP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .seed(seed0), .seed_valid(sv0), .seed_ready(rdy0),
    .en(en0), .r(r0), .common_out(co0), .mask_valid(mv0)
  );

  comar_mask_gen #(.WARMUP_CYCLES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .seed(seed1), .seed_valid(sv1), .seed_ready(rdy1),
    .en(en1), .r(r1), .common_out(co1), .mask_valid(mv1)
  );

  function automatic logic [31:0] ref_adv(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int k = 0; k < 6; k++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    return t;
  endfunction

  function automatic logic [31:0] ref_warm(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int k = 0; k < 16; k++) t = ref_adv(t);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_lf[i] = 32'h0; m_cnt[i] = 0; m_co[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Reference behaviour for one rising edge; pushes the outputs expected after it.
  task automatic model_edge(input int i, input logic sv, input logic [31:0] sd, input logic e);
    exp_t x;
    case (m_st[i])
      1: begin
        m_lf[i] = ref_adv(m_lf[i]);
        if (m_cnt[i] == 1) m_st[i] = 2;
        m_cnt[i]--;
      end
      default: begin
        if (sv) begin
          m_lf[i]  = (sd == 32'h0) ? 32'h1 : sd;
          m_cnt[i] = m_w[i];
          m_co[i]  = 1'b0;
          m_st[i]  = (m_w[i] > 0) ? 1 : 2;
        end else if (m_st[i] == 2 && e) begin
          m_co[i] = ^m_lf[i][5:2];
          m_lf[i] = ref_adv(m_lf[i]);
        end
      end
    endcase
    x.v   = (m_st[i] == 2);
    x.r   = x.v ? m_lf[i][5:0] : 6'h0;
    x.c   = m_co[i];
    x.rdy = (m_st[i] != 1);
    if (i == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic cycle();
    exp_t x;
    model_edge(0, sv0 & rst_n, seed0, en0);
    model_edge(1, sv1 & rst_n, seed1, en1);
    @(posedge clk);
    #1;
    x = q0.pop_front();
    chk("d0_r", 32'(r0), 32'(x.r));
    chk("d0_common", 32'(co0), 32'(x.c));
    chk("d0_valid", 32'(mv0), 32'(x.v));
    chk("d0_ready", 32'(rdy0), 32'(x.rdy));
    x = q1.pop_front();
    chk("d1_r", 32'(r1), 32'(x.r));
    chk("d1_common", 32'(co1), 32'(x.c));
    chk("d1_valid", 32'(mv1), 32'(x.v));
    chk("d1_ready", 32'(rdy1), 32'(x.rdy));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_r0"}, 32'(r0), 32'h0);
    chk({tag, "_mv0"}, 32'(mv0), 32'h0);
    chk({tag, "_rdy0"}, 32'(rdy0), 32'h1);
    chk({tag, "_co0"}, 32'(co0), 32'h0);
    chk({tag, "_r1"}, 32'(r1), 32'h0);
    chk({tag, "_mv1"}, 32'(mv1), 32'h0);
    chk({tag, "_rdy1"}, 32'(rdy1), 32'h1);
    chk({tag, "_co1"}, 32'(co1), 32'h0);
  endtask

  initial begin
    seed0 = 32'h0; sv0 = 1'b0; en0 = 1'b0;
    seed1 = 32'h0; sv1 = 1'b0; en1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("por");
    rst_n = 1'b1;
    cycle();

    // WARMUP_CYCLES=0, seed 1, en held high
    seed0 = 32'h1; sv0 = 1'b1; en0 = 1'b1;
    cycle();
    sv0 = 1'b0;
    chk("w0_first_r", 32'(r0), 32'h01);
    chk("w0_first_valid", 32'(mv0), 32'h1);
    cycle();
    chk("w0_second_r", 32'(r0), 32'h2D);
    chk("w0_common_1st", 32'(co0), 32'h0);
    cycle();
    chk("w0_common_2nd", 32'(co0), 32'h1);
    repeat (4) cycle();

    // stall then resume
    en0 = 1'b0;
    repeat (5) cycle();
    en0 = 1'b1;
    repeat (3) cycle();

    // zero seed offered in RUN with en high: reseed wins, sequence restarts from 1
    seed0 = 32'h0; sv0 = 1'b1;
    cycle();
    sv0 = 1'b0;
    chk("zs_first_r", 32'(r0), 32'h01);
    chk("zs_common_clr", 32'(co0), 32'h0);
    cycle();
    chk("zs_second_r", 32'(r0), 32'h2D);
    chk("zs_common_1st", 32'(co0), 32'h0);
    cycle();
    chk("zs_common_2nd", 32'(co0), 32'h1);
    en0 = 1'b0;

    // WARMUP_CYCLES=16 timing
    seed1 = 32'h1234_5678; sv1 = 1'b1; en1 = 1'b1;
    cycle();
    sv1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("warm_ready_low", 32'(rdy1), 32'h0);
      chk("warm_valid_low", 32'(mv1), 32'h0);
      cycle();
    end
    chk("warm_done_valid", 32'(mv1), 32'h1);
    chk("warm_done_r", 32'(r1), 32'(ref_warm(32'h1234_5678) & 32'h3F));
    repeat (5) cycle();

    // reseed in RUN with en high
    seed1 = 32'hDEAD_BEEF; sv1 = 1'b1;
    cycle();
    sv1 = 1'b0;
    chk("reseed_valid_drop", 32'(mv1), 32'h0);
    chk("reseed_common_clr", 32'(co1), 32'h0);
    chk("reseed_ready_low", 32'(rdy1), 32'h0);
    repeat (16) cycle();
    chk("reseed_valid", 32'(mv1), 32'h1);
    chk("reseed_r", 32'(r1), 32'(ref_warm(32'hDEAD_BEEF) & 32'h3F));
    en0 = 1'b1;
    repeat (3) cycle();

    // async reset mid-RUN, away from any edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async");
    model_reset();
    #2;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk_reset_outs("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
